// File: rtl/riscv_defs_pkg.sv
// Shared RV32I definitions for the front end: major opcodes, address width,
// immediate extraction helpers and the fetch FSM state type.
package riscv_defs;

    localparam int unsigned ADDR_WIDTH = 32;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    typedef enum logic [1:0] {
        StFetch,
        StHold,
        StWaitJalr
    } if_state_e;

    // Raw 21-bit J-type offset; bit 0 is always zero.
    function automatic logic [20:0] j_imm(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Raw 13-bit B-type offset; bit 0 is always zero.
    function automatic logic [12:0] b_imm(input logic [31:0] inst);
        return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/if_next_pc.sv
// Speculative next-PC computation for one fetched instruction word.
module if_next_pc #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [31:0]           inst,
    input  logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  is_jalr
);
    import riscv_defs::*;

    logic [20:0] jimm;
    logic [12:0] bimm;
    logic [ADDR_WIDTH-1:0] jimm_ext;
    logic [ADDR_WIDTH-1:0] bimm_ext;

    assign jimm     = j_imm(inst);
    assign bimm     = b_imm(inst);
    assign jimm_ext = {{(ADDR_WIDTH-21){jimm[20]}}, jimm};
    assign bimm_ext = {{(ADDR_WIDTH-13){bimm[12]}}, bimm};

    always_comb begin
        next_pc = pc + ADDR_WIDTH'(4);
        is_jalr = 1'b0;
        case (inst[6:0])
            OPC_JAL:    next_pc = pc + jimm_ext;
            OPC_BRANCH: if (predict_taken) next_pc = pc + bimm_ext;
            OPC_JALR:   is_jalr = 1'b1;
            default:    ;
        endcase
    end

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: sequences the PC, talks to the I-cache and predictor, and hands
// one-cycle instruction packets to the decoder.
module instruction_fetcher #(
    parameter int unsigned           ADDR_WIDTH = riscv_defs::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    output logic                  IFIC_en,
    output logic [ADDR_WIDTH-1:0] IFIC_addr,
    input  logic                  ICIF_en,
    input  logic [31:0]           ICIF_data,
    output logic [ADDR_WIDTH-1:0] IFPD_pc,
    input  logic                  PDIF_predict_result,
    input  logic                  DPIF_stall,
    input  logic                  ROBIF_jump_en,
    input  logic [ADDR_WIDTH-1:0] ROBIF_jump_addr,
    output logic                  IFDC_en,
    output logic [ADDR_WIDTH-1:0] IFDC_pc,
    output logic [6:0]            IFDC_opcode,
    output logic [24:0]           IFDC_remain_inst,
    output logic                  IFDC_predict_result
);
    import riscv_defs::*;

    if_state_e             state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [31:0]           inst_q;
    logic                  hold_valid_q;
    logic                  drop_pending_q;
    logic                  lost_q;
    logic                  in_rst_q;

    logic [31:0]           cur_inst;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  is_jalr;
    logic                  is_branch;
    logic                  outstanding;
    logic                  issue;

    assign cur_inst  = (state_q == StHold) ? inst_q : ICIF_data;
    assign is_branch = (cur_inst[6:0] == OPC_BRANCH);
    assign IFPD_pc   = pc_q;
    // A cache answer is still owed and will not arrive this cycle.
    assign outstanding = (IFIC_en || drop_pending_q || lost_q) && !ICIF_en;
    assign issue = !DPIF_stall &&
                   ((state_q == StFetch && ICIF_en && !drop_pending_q) ||
                    (state_q == StHold && hold_valid_q));

    if_next_pc #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_next_pc (
        .pc           (pc_q),
        .inst         (cur_inst),
        .predict_taken(PDIF_predict_result),
        .next_pc      (next_pc),
        .is_jalr      (is_jalr)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q             <= StFetch;
            pc_q                <= RESET_PC;
            inst_q              <= '0;
            hold_valid_q        <= 1'b0;
            drop_pending_q      <= 1'b0;
            // Remember a request interrupted by the first reset cycle; its
            // answer must be swallowed once reset is released.
            lost_q              <= in_rst_q ? (lost_q && !ICIF_en) : outstanding;
            in_rst_q            <= 1'b1;
            IFIC_en             <= 1'b1;
            IFIC_addr           <= RESET_PC;
            IFDC_en             <= 1'b0;
            IFDC_pc             <= '0;
            IFDC_opcode         <= '0;
            IFDC_remain_inst    <= '0;
            IFDC_predict_result <= 1'b0;
        end else if (rdy_in) begin
            in_rst_q <= 1'b0;
            IFDC_en  <= 1'b0;
            if (ROBIF_jump_en) begin
                state_q        <= StFetch;
                pc_q           <= ROBIF_jump_addr;
                hold_valid_q   <= 1'b0;
                lost_q         <= 1'b0;
                drop_pending_q <= outstanding;
                IFIC_en        <= !outstanding;
                IFIC_addr      <= ROBIF_jump_addr;
            end else if (lost_q) begin
                lost_q         <= 1'b0;
                drop_pending_q <= !ICIF_en;
                IFIC_en        <= ICIF_en;
            end else if (issue) begin
                IFDC_en             <= 1'b1;
                IFDC_pc             <= pc_q;
                IFDC_opcode         <= cur_inst[6:0];
                IFDC_remain_inst    <= cur_inst[31:7];
                IFDC_predict_result <= is_branch && PDIF_predict_result;
                inst_q              <= cur_inst;
                hold_valid_q        <= 1'b0;
                if (is_jalr) begin
                    state_q <= StWaitJalr;
                    IFIC_en <= 1'b0;
                end else begin
                    state_q   <= StFetch;
                    pc_q      <= next_pc;
                    IFIC_en   <= 1'b1;
                    IFIC_addr <= next_pc;
                end
            end else if (state_q == StFetch && ICIF_en) begin
                if (drop_pending_q) begin
                    drop_pending_q <= 1'b0;
                    IFIC_en        <= 1'b1;
                    IFIC_addr      <= pc_q;
                end else begin
                    inst_q       <= ICIF_data;
                    hold_valid_q <= 1'b1;
                    state_q      <= StHold;
                    IFIC_en      <= 1'b0;
                end
            end
        end
    end

endmodule
